// File: rtl/zhegalkin_pkg.sv
// Shared constants and helpers for the Zhegalkin (ANF) transformer.
// State encodings are plain localparams so older tools that lack enum support can read them.
package zhegalkin_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StXform = 2'd1;
  localparam state_t StDeg   = 2'd2;
  localparam state_t StDone  = 2'd3;

  localparam logic MODE_TT2ANF = 1'b0;
  localparam logic MODE_ANF2TT = 1'b1;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/zhegalkin_xform_if.sv
// Handshake bundle for the Zhegalkin transformer: request side and result side.
interface zhegalkin_xform_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned TT_W  = 2 ** N;
  localparam int unsigned DEG_W = $clog2(N + 1);

  logic             in_valid;
  logic             in_ready;
  logic [TT_W-1:0]  in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [TT_W-1:0]  out_data;
  logic             out_mode;
  logic [DEG_W-1:0] out_degree;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_degree, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_degree, out_zero
  );

endinterface

// File: rtl/zhegalkin_stage.sv
// One binary Moebius butterfly pass over variable k: d[i] ^= d[i ^ (1<<k)] where bit k of i is set.
module zhegalkin_stage #(
  parameter int unsigned N = 4,
  localparam int unsigned TT_W = 2 ** N,
  localparam int unsigned KW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [TT_W-1:0] data,
  input  logic [KW-1:0]   k,
  output logic [TT_W-1:0] result
);

  logic [N-1:0] idx;

  always_comb begin
    result = data;
    idx    = '0;
    for (int unsigned i = 0; i < TT_W; i++) begin
      idx = N'(i);
      if (idx[k]) begin
        result[i] = data[i] ^ data[idx ^ (N'(1) << k)];
      end
    end
  end

endmodule

// File: rtl/zhegalkin_xform.sv
// Sequential ANF transformer: one butterfly pass per clock, then a degree/zero summary cycle.
// The transform is its own inverse; mode only picks which side the degree is read from.
module zhegalkin_xform
  import zhegalkin_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input logic           clk,
  input logic           rst_n,
  zhegalkin_xform_if.slave bus
);

  localparam int unsigned TT_W  = 2 ** N;
  localparam int unsigned DEG_W = $clog2(N + 1);
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [TT_W-1:0]  data_q, data_d;
  logic [TT_W-1:0]  inp_q, inp_d;
  logic             mode_q, mode_d;
  logic [DEG_W-1:0] deg_q, deg_d;
  logic             zero_q, zero_d;

  logic [TT_W-1:0]  stage_out;
  logic [TT_W-1:0]  anf;
  logic [DEG_W-1:0] deg_calc;

  zhegalkin_stage #(
    .N (N)
  ) u_stage (
    .data   (data_q),
    .k      (k_q),
    .result (stage_out)
  );

  // In ANF->TT mode the coefficients are the captured input, not the result.
  always_comb begin
    anf      = (mode_q == MODE_TT2ANF) ? data_q : inp_q;
    deg_calc = '0;
    for (int unsigned i = 0; i < TT_W; i++) begin
      if (anf[i] && (DEG_W'(popcount(i)) > deg_calc)) begin
        deg_calc = DEG_W'(popcount(i));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    inp_d   = inp_q;
    mode_d  = mode_q;
    deg_d   = deg_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          inp_d   = bus.in_data;
          mode_d  = bus.in_mode;
          k_d     = '0;
          state_d = StXform;
        end
      end
      StXform: begin
        data_d = stage_out;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          state_d = StDeg;
        end
      end
      StDeg: begin
        deg_d   = deg_calc;
        zero_d  = ~|anf;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      data_q  <= '0;
      inp_q   <= '0;
      mode_q  <= 1'b0;
      deg_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      inp_q   <= inp_d;
      mode_q  <= mode_d;
      deg_q   <= deg_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_data   = data_q;
  assign bus.out_mode   = mode_q;
  assign bus.out_degree = deg_q;
  assign bus.out_zero   = zero_q;

endmodule

// File: tb/tb_zhegalkin_xform.sv
// Scoreboard bench for zhegalkin_xform at N=4 and N=2 against a subset-sum ANF reference model.
module tb_zhegalkin_xform;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  typedef struct {
    logic [63:0] data;
    logic        mode;
    int          deg;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  exp_t e4, e2, eb;
  logic v4_prev = 1'b0;
  logic v2_prev = 1'b0;

  zhegalkin_xform_if #(.N(4)) if4 ();
  zhegalkin_xform_if #(.N(2)) if2 ();

  zhegalkin_xform #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  zhegalkin_xform #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // a[u] = XOR of f[x] over every x that is a subset of u
  function automatic logic [63:0] mobius(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int u = 0; u < (1 << n); u++)
      for (int x = 0; x < (1 << n); x++)
        if ((x & ~u) == 0) r[u] = r[u] ^ v[x];
    return r;
  endfunction

  function automatic int degree(input logic [63:0] a, input int n);
    int d;
    d = 0;
    for (int u = 0; u < (1 << n); u++)
      if (a[u] && $countones(u) > d) d = $countones(u);
    return d;
  endfunction

  function automatic exp_t model(input logic [63:0] d, input logic m, input int n, input int acc);
    exp_t        e;
    logic [63:0] a;
    e.data = mobius(d, n);
    a      = m ? d : e.data;
    e.mode = m;
    e.deg  = degree(a, n);
    e.zero = (a == 64'd0);
    e.acc  = acc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (if4.out_valid && !v4_prev) begin
        if (q4.size() == 0) fail("spurious_valid4");
        else chk("latency4", 64'(cyc - q4[0].acc), 64'd5);
      end
      if (if4.out_valid && if4.out_ready) begin
        if (q4.size() == 0) fail("unexpected_out4");
        else begin
          e4 = q4.pop_front();
          chk("data4", 64'(if4.out_data), e4.data);
          chk("mode4", 64'(if4.out_mode), 64'(e4.mode));
          chk("degree4", 64'(if4.out_degree), 64'(e4.deg));
          chk("zero4", 64'(if4.out_zero), 64'(e4.zero));
        end
      end
    end
    v4_prev = if4.out_valid;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (if2.out_valid && !v2_prev) begin
        if (q2.size() == 0) fail("spurious_valid2");
        else chk("latency2", 64'(cyc - q2[0].acc), 64'd3);
      end
      if (if2.out_valid && if2.out_ready) begin
        if (q2.size() == 0) fail("unexpected_out2");
        else begin
          e2 = q2.pop_front();
          chk("data2", 64'(if2.out_data), e2.data);
          chk("mode2", 64'(if2.out_mode), 64'(e2.mode));
          chk("degree2", 64'(if2.out_degree), 64'(e2.deg));
          chk("zero2", 64'(if2.out_zero), 64'(e2.zero));
        end
      end
    end
    v2_prev = if2.out_valid;
  end

  task automatic send4(input logic [15:0] d, input logic m);
    int t;
    t = 0;
    while (!if4.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!if4.in_ready) begin
      fail("send4_timeout");
      return;
    end
    if4.in_valid = 1'b1;
    if4.in_data  = d;
    if4.in_mode  = m;
    q4.push_back(model(64'(d), m, 4, cyc + 1));
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [3:0] d, input logic m);
    int t;
    t = 0;
    while (!if2.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!if2.in_ready) begin
      fail("send2_timeout");
      return;
    end
    if2.in_valid = 1'b1;
    if2.in_data  = d;
    if2.in_mode  = m;
    q2.push_back(model(64'(d), m, 2, cyc + 1));
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int t;
    t = 0;
    while (q4.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (q4.size() != 0) fail("drain4_timeout");
  endtask

  task automatic drain2();
    int t;
    t = 0;
    while (q2.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (q2.size() != 0) fail("drain2_timeout");
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_in_ready"}, 64'(if4.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(if4.out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(if4.out_data), 64'd0);
    chk({tag, "_out_mode"}, 64'(if4.out_mode), 64'd0);
    chk({tag, "_out_degree"}, 64'(if4.out_degree), 64'd0);
    chk({tag, "_out_zero"}, 64'(if4.out_zero), 64'd0);
  endtask

  initial begin
    int          t;
    logic [15:0] d;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.in_mode = 1'b0; if4.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_mode = 1'b0; if2.out_ready = 1'b1;
    #12;
    chk_reset4("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed vectors
    send4(16'h0AC5, 1'b0); drain4();
    send4(16'h5173, 1'b1); drain4();
    send4(16'h0000, 1'b0); drain4();
    send4(16'hFFFF, 1'b0); drain4();
    send4(16'h0001, 1'b0); drain4();

    // random back-to-back jobs
    repeat (20) send4(16'($urandom), 1'($urandom_range(0, 1)));
    drain4();

    // backpressure: hold the result while in_valid/in_data wiggle
    if4.out_ready = 1'b0;
    d  = 16'($urandom);
    eb = model(64'(d), 1'b0, 4, 0);
    send4(d, 1'b0);
    t = 0;
    while (!if4.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!if4.out_valid) fail("bp_valid_timeout");
    for (int i = 0; i < 6; i++) begin
      if4.in_valid = ~if4.in_valid;
      if4.in_data  = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(if4.out_valid), 64'd1);
      chk("bp_out_data", 64'(if4.out_data), eb.data);
      chk("bp_out_degree", 64'(if4.out_degree), 64'(eb.deg));
      chk("bp_in_ready", 64'(if4.in_ready), 64'd0);
    end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", 64'(if4.out_valid), 64'd0);
    chk("bp_in_ready_rise", 64'(if4.in_ready), 64'd1);
    send4(16'($urandom), 1'($urandom_range(0, 1)));
    drain4();

    // asynchronous reset in the middle of pass 2
    send4(16'h0AC5, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset4("midrst");
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send4(16'h0AC5, 1'b0);
    drain4();

    // two-variable instance
    send2(4'h8, 1'b0); drain2();
    send2(4'h6, 1'b0); drain2();
    repeat (10) send2(4'($urandom), 1'($urandom_range(0, 1)));
    drain2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zhegalkin_xform.md
Name: zhegalkin_xform

Overview:
Parametrised, sequential Zhegalkin (algebraic normal form, ANF) transformer for Boolean functions of N variables.
- Accepts a 2^N-bit vector over a valid/ready handshake and runs the binary Möbius butterfly, one variable pass per clock.
- Returns the transformed vector, the polynomial degree and a zero-function flag.
- Successor to the fixed 4-input hard-wired Zhegalkin polynomial: converts truth table to ANF coefficients (mode 0) or ANF to truth table (mode 1) for any N.

Parameters:
- N, 4, number of Boolean variables; legal range 1..6.
- TT_W, 2**N, vector width; localparam, not overridable.
- DEG_W, $clog2(N+1), degree output width; localparam.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input vector present.
- in_ready  output  1  block can accept (high only in IDLE).
- in_data  input  TT_W  bit i = value or coefficient at index i; index bit k = variable x_k.
- in_mode  input  1  0: truth table to ANF; 1: ANF to truth table.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  TT_W  transformed vector.
- out_mode  output  1  echo of the captured in_mode.
- out_degree  output  DEG_W  max popcount(i) over all ANF coefficients with bit i = 1; 0 for the zero function.
- out_zero  output  1  ANF vector is all zeros.

Behaviour:
- Reset (asynchronous, any state, including mid-transform): state IDLE, pass counter 0, data register 0, in_ready=1, out_valid=0, out_data=0, out_mode=0, out_degree=0, out_zero=0. An in-flight job is discarded.
- States: IDLE, XFORM, DEG, DONE.
- IDLE: in_ready=1. On clock edge E with in_valid=1: capture in_data and in_mode, clear k, go to XFORM. With in_valid=0, stay.
- XFORM: one pass per edge, in_ready=0. Pass k does d[i] ^= d[i ^ (1<<k)] for every i with bit k set, using values from before the edge. Increment k. After pass N-1 (edge E+N), go to DEG.
- DEG: one cycle.
  - The ANF vector is the result in mode 0 and the captured input in mode 1; an input copy is held for mode 1.
  - Register out_degree and out_zero from the ANF vector.
  - Go to DONE at edge E+N+1.
- DONE: out_valid=1 from edge E+N+1; out_data, out_mode, out_degree and out_zero stay stable while out_ready=0.
  - When out_ready=1 at an edge: out_valid drops, go to IDLE, in_ready rises the following cycle.
  - in_valid is ignored outside IDLE.
- Latency: N+1 edges from accept to out_valid. Throughput: one job per N+3 cycles minimum. No overlap of jobs.
- The transform is an involution: mode only selects which side the degree is computed on. out_data = Möbius(in_data) in both modes.
- Degree arithmetic: unsigned, DEG_W bits; maximum value N, so it never overflows.

Decomposition:
- Package zhegalkin_pkg: state enum (IDLE, XFORM, DEG, DONE), mode constants MODE_TT2ANF=0 and MODE_ANF2TT=1, and a popcount function.
- Sub-module zhegalkin_stage (combinational, parameter N): inputs data vector and pass index k, output the vector after one butterfly pass. It is instantiated once and muxed by k.
- Degree logic stays inline, using the package function.

Test Plan:
- N=4, mode 0, in_data=0x0AC5 -> out_data=0x5173, out_degree=3, out_zero=0. out_valid rises exactly 5 edges after accept. This is the function 1^x0^x2^x3^x0x2^x1x2^x2x3^x1x2x3.
- N=4, mode 1, in_data=0x5173 -> out_data=0x0AC5, out_degree=3, out_mode=1.
- N=4, mode 0, inputs 0x0000 / 0xFFFF / 0x0001:
  - 0x0000 -> out 0x0000, degree 0, out_zero=1.
  - 0xFFFF -> out 0x0001, degree 0, out_zero=0.
  - 0x0001 -> out 0xFFFF, degree 4.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid and in_data -> outputs stable, in_ready=0, no second capture. After out_ready=1, in_ready=1 on the next cycle. A back-to-back second job then returns its own correct result.
- Reset: assert rst_n=0 during XFORM pass 2 -> all outputs read reset values immediately (asynchronously). Release, then a fresh job 0x0AC5 still returns 0x5173.
- N=2 instance, mode 0: 0x8 (AND) -> out 0x8, degree 2; 0x6 (XOR) -> out 0x6, degree 1. out_valid rises 3 edges after accept.
